// File: rtl/dma_copy_master.sv
// dma_copy_master: bus initiator that copies a block of words from src to dst, one read then one write per word
module dma_copy_master #(
  parameter int         LEN_W       = 16,
  parameter logic [3:0] ACCESS_MASK = 4'b1111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic [LEN_W-1:0] words_done,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wrdata,
  output logic             mem_memwrite,
  output logic             mem_memread,
  output logic [3:0]       mem_sign_mask,
  input  logic [31:0]      mem_rddata,
  input  logic             mem_clk_stall
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;
  state_t           r_state;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic             r_abort_pend;
  logic [LEN_W-1:0] w_next;
  logic             w_abort;
  assign w_next        = words_done + LEN_W'(1);
  assign w_abort       = r_abort_pend | abort;
  assign mem_sign_mask = ACCESS_MASK;
  // command sequencer; mem_wrdata doubles as the word buffer between read and write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_abort_pend <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      aborted      <= 1'b0;
      words_done   <= '0;
      mem_addr     <= '0;
      mem_wrdata   <= '0;
      mem_memwrite <= 1'b0;
      mem_memread  <= 1'b0;
    end else begin
      if (r_state != IDLE) r_abort_pend <= r_abort_pend | abort;
      case (r_state)
        IDLE: if (start) begin
          r_src        <= src_addr;
          r_dst        <= dst_addr;
          r_len        <= len_words;
          words_done   <= '0;
          aborted      <= 1'b0;
          r_abort_pend <= 1'b0;
          busy         <= 1'b1;
          err          <= |(src_addr[1:0] | dst_addr[1:0]);
          if (|(src_addr[1:0] | dst_addr[1:0]) || len_words == '0) begin
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            mem_memread <= 1'b1;
            mem_addr    <= src_addr;
            r_state     <= RD_REQ;
          end
        end
        RD_REQ: r_state <= RD_WAIT;
        RD_WAIT: if (!mem_clk_stall) begin
          mem_memread  <= 1'b0;
          mem_memwrite <= 1'b1;
          mem_addr     <= r_dst;
          mem_wrdata   <= mem_rddata;
          r_state      <= WR_REQ;
        end
        WR_REQ, WR_WAIT: if (!mem_clk_stall) begin
          mem_memwrite <= 1'b0;
          words_done   <= w_next;
          r_src        <= r_src + 32'd4;
          r_dst        <= r_dst + 32'd4;
          if (w_next == r_len || w_abort) begin
            aborted <= w_abort;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            mem_memread <= 1'b1;
            mem_addr    <= r_src + 32'd4;
            r_state     <= RD_REQ;
          end
        end else r_state <= WR_WAIT;
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_copy_master.sv
// tb_dma_copy_master: directed and randomized copy commands against a word-array memory model
module tb_dma_copy_master;
  logic        clk = 1'b0;
  logic        reset, start, abort, busy, done, err, aborted;
  logic [31:0] src_addr, dst_addr, mem_addr, mem_wrdata, mem_rddata;
  logic [15:0] len_words, words_done;
  logic        mem_memwrite, mem_memread, mem_clk_stall;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem [1024];
  logic [31:0] exp_mem [1024];
  logic        fill;
  int          n_cmp = 0, n_bad = 0;
  int          stall_mode = 0, rdc = 0, wrc = 0;
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic        p_rd = 1'b0, p_wr = 1'b0;
  logic [31:0] p_addr = '0, p_data = '0;
  logic [31:0] rd_q [$];

  dma_copy_master #(.LEN_W(16), .ACCESS_MASK(4'b1111)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .abort(abort), .busy(busy), .done(done), .err(err),
    .aborted(aborted), .words_done(words_done), .mem_addr(mem_addr), .mem_wrdata(mem_wrdata),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
    .mem_rddata(mem_rddata), .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  assign mem_rddata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 1024; i++) mem[i] <= $urandom;
    else if (mem_memwrite && !mem_clk_stall) mem[mem_addr[11:2]] <= mem_wrdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    rdc <= mem_memread ? rdc + 1 : 0;
    wrc <= mem_memwrite ? wrc + 1 : 0;
    case (stall_mode)
      1:       mem_clk_stall <= ($urandom_range(0, 3) == 0);
      2:       mem_clk_stall <= (mem_memread && rdc + 1 >= 2 && rdc + 1 <= 3) || (mem_memwrite && wrc + 1 <= 4);
      3:       mem_clk_stall <= 1'b1;
      default: mem_clk_stall <= 1'b0;
    endcase
  end

  always @(negedge clk) begin
    chk("rd_wr_exclusive", 32'(mem_memread & mem_memwrite), 32'd0);
    if (mem_memread && p_rd) chk("rd_addr_hold", mem_addr, p_addr);
    if (mem_memwrite && p_wr) begin
      chk("wr_addr_hold", mem_addr, p_addr);
      chk("wr_data_hold", mem_wrdata, p_data);
    end
    if (mem_memread && !p_rd) begin
      rd_q.push_back(mem_addr);
      rd_cnt++;
    end
    if (mem_memwrite && !p_wr) wr_cnt++;
    if (done) done_cnt++;
    p_rd   <= mem_memread;
    p_wr   <= mem_memwrite;
    p_addr <= mem_addr;
    p_data <= mem_wrdata;
  end

  task automatic snapshot();
    for (int i = 0; i < 1024; i++) exp_mem[i] = mem[i];
  endtask

  task automatic mem_check(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
    int diff = 0;
    for (int i = 0; i < n; i++) exp_mem[(int'(d[11:2]) + i) % 1024] = exp_mem[(int'(s[11:2]) + i) % 1024];
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) diff++;
    chk({tag, "_mem_diff"}, 32'(diff), 32'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] s, input logic [31:0] d, input int len,
                     input int abort_word, input int smode, input bit extra_start);
    int  n_exp, rd0, wr0, dc0;
    bit  got, err_exp, ab_exp;
    stall_mode = smode;
    @(negedge clk);
    snapshot();
    rd_q.delete();
    rd0 = rd_cnt; wr0 = wr_cnt; dc0 = done_cnt;
    src_addr = s; dst_addr = d; len_words = 16'(len); start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    err_exp = (s[1:0] | d[1:0]) != 2'b00;
    ab_exp  = !err_exp && abort_word > 0 && abort_word < len;
    n_exp   = err_exp ? 0 : ab_exp ? abort_word : len;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      abort = abort_word > 0 && int'(words_done) == abort_word - 1 && mem_memread;
      start = extra_start && c == 3;
      if (start) begin
        src_addr  = 32'h40;
        dst_addr  = 32'h80;
        len_words = 16'd7;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(err_exp));
    chk({tag, "_aborted"}, 32'(aborted), 32'(ab_exp));
    chk({tag, "_words_done"}, 32'(words_done), 32'(n_exp));
    @(negedge clk);
    chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt - dc0), 32'd1);
    chk({tag, "_reads"}, 32'(rd_cnt - rd0), 32'(n_exp));
    chk({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(n_exp));
    chk({tag, "_words_hold"}, 32'(words_done), 32'(n_exp));
    mem_check(tag, s, d, n_exp);
  endtask

  initial begin
    int  len, ab;
    logic [31:0] s, d;
    bit  got;
    reset = 1'b1; start = 1'b0; abort = 1'b0; fill = 1'b1;
    src_addr = '0; dst_addr = '0; len_words = '0;
    @(negedge clk);
    @(negedge clk);
    fill = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_memread", 32'(mem_memread), 32'd0);
    chk("rst_memwrite", 32'(mem_memwrite), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wrdata", mem_wrdata, 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    chk("sign_mask", 32'(mem_sign_mask), 32'hF);
    reset = 1'b0;

    // reset asserted while stalled in the read wait of the second word
    @(negedge clk);
    snapshot();
    src_addr = 32'h100; dst_addr = 32'h200; len_words = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (words_done == 16'd1 && mem_memread) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_rst_reached", 32'(got), 32'd1);
    stall_mode = 3;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_pre_memread", 32'(mem_memread), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_memread", 32'(mem_memread), 32'd0);
    chk("mid_rst_memwrite", 32'(mem_memwrite), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_words_done", 32'(words_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stall_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_memread", 32'(mem_memread), 32'd0);
    mem_check("mid_rst", 32'h100, 32'h200, 1);

    run("copy3", 32'h100, 32'h200, 3, 0, 0, 1'b0);
    run("stall1", 32'h300, 32'h500, 1, 0, 2, 1'b0);
    run("len0", 32'h100, 32'h200, 0, 0, 0, 1'b0);
    run("misalign", 32'h102, 32'h200, 3, 0, 0, 1'b0);
    run("abort2", 32'h140, 32'h600, 5, 2, 0, 1'b0);
    run("wrap", 32'hFFFF_FFFC, 32'h400, 2, 0, 0, 1'b1);
    chk("wrap_reads", 32'(rd_q.size()), 32'd2);
    if (rd_q.size() > 1) chk("wrap_second_addr", rd_q[1], 32'h0);

    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, 8);
      ab  = ($urandom_range(0, 1) == 1 && len > 1) ? $urandom_range(1, len - 1) : 0;
      s   = 32'($urandom_range(0, 255)) << 2;
      d   = 32'($urandom_range(512, 767)) << 2;
      run($sformatf("rand%0d", k), s, d, len, ab, 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
